// File: rtl/top_level_dec.sv
// rtl/top_level_dec.sv - RSA decryption engine, message = cipher^d_key mod n
//
// Left-to-right square-and-multiply over a bit-serial interleaved modular
// multiplier (one multiplier bit per cycle, shift/add/conditional-subtract).
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset, aborts any operation
//   start    in   request, sampled only in IDLE
//   cipher   in   W  ciphertext c (must be < n)
//   d_key    in   W  private exponent d
//   n        in   W  modulus (must be >= 2)
//   message  out  W  result register
//   done     out  one-cycle pulse when message/err are valid
//   busy     out  high from accept through the done cycle
//   err      out  set with done on invalid operands, held until next accept

module top_level_dec #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] cipher,
  input  logic [W-1:0] d_key,
  input  logic [W-1:0] n,
  output logic [W-1:0] message,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(W + 1);
  localparam int MW = $clog2(W);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, SQ, MUL, NEXT, DONE} state_t;

  state_t         state;
  logic [W-1:0]   c_reg;
  logic [W-1:0]   d_reg;   // exponent, shifted left so the current bit is d_reg[W-1]
  logic [W-1:0]   n_reg;
  logic [W-1:0]   acc;
  logic [W-1:0]   r;       // modmul partial remainder, always < n between cycles
  logic [CW-1:0]  cnt;     // exponent bits still to consume
  logic [MW-1:0]  mcnt;    // modmul multiplier bit index, W-1 downto 0

  // One modmul iteration. Intermediates are W+2 bits wide so 2R and R+a are
  // compared against n without truncation; after a conditional subtract the
  // true value is < n, so the low W bits of the difference are exact.
  logic [W+1:0] n_ext;
  logic [W+1:0] a_ext;
  logic [W+1:0] r_dbl;
  logic [W-1:0] r_dbl_red;
  logic [W+1:0] r_add;
  logic [W-1:0] r_add_red;
  logic [W-1:0] r_next;
  logic         mul_bit;

  always_comb begin
    n_ext     = {2'b00, n_reg};
    a_ext     = {2'b00, acc};
    // Squaring multiplies acc by itself; multiply step uses the ciphertext.
    mul_bit   = (state == SQ) ? acc[mcnt] : c_reg[mcnt];
    r_dbl     = {1'b0, r, 1'b0};
    r_dbl_red = (r_dbl >= n_ext) ? (r_dbl[W-1:0] - n_reg) : r_dbl[W-1:0];
    r_add     = {2'b00, r_dbl_red} + a_ext;
    r_add_red = (r_add >= n_ext) ? (r_add[W-1:0] - n_reg) : r_add[W-1:0];
    r_next    = mul_bit ? r_add_red : r_dbl_red;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      c_reg   <= '0;
      d_reg   <= '0;
      n_reg   <= '0;
      acc     <= '0;
      r       <= '0;
      cnt     <= '0;
      mcnt    <= '0;
      message <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            c_reg <= cipher;
            d_reg <= d_key;
            n_reg <= n;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= CHECK;
          end else begin
            busy <= 1'b0;
          end
        end

        CHECK: begin
          if (n_reg < W'(2) || c_reg >= n_reg) begin
            message <= '0;
            err     <= 1'b1;
            state   <= DONE;
          end else begin
            acc <= W'(1);
            cnt <= CW'(W);
            // A set MSB skips the scan entirely; otherwise SCAN looks one
            // bit ahead so the first square starts without a dead cycle.
            if (d_reg[W-1]) begin
              r     <= '0;
              mcnt  <= MW'(W - 1);
              state <= SQ;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          d_reg <= d_reg << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            message <= W'(1);
            state   <= DONE;
          end else if (d_reg[W-2]) begin
            r     <= '0;
            mcnt  <= MW'(W - 1);
            state <= SQ;
          end
        end

        SQ: begin
          r    <= r_next;
          mcnt <= mcnt - MW'(1);
          if (mcnt == '0) begin
            acc   <= r_next;
            r     <= '0;
            mcnt  <= MW'(W - 1);
            state <= d_reg[W-1] ? MUL : NEXT;
          end
        end

        MUL: begin
          r    <= r_next;
          mcnt <= mcnt - MW'(1);
          if (mcnt == '0) begin
            acc   <= r_next;
            state <= NEXT;
          end
        end

        NEXT: begin
          d_reg <= d_reg << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            message <= acc;
            state   <= DONE;
          end else begin
            r     <= '0;
            mcnt  <= MW'(W - 1);
            state <= SQ;
          end
        end

        DONE: begin
          // busy stays high through the pulse cycle; IDLE drops it.
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
